// File: rtl/spi_tx_module.sv
// SPI master transmitter (CPOL=0, MSB first, SCK = spi_clk/2) with a one-entry
// holding register so consecutive bytes stream under a single CS_N assertion.
module spi_tx_module #(
  parameter int DATA_W = 8
) (
  input  logic              spi_clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              write_rq,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              SPI_MOSI,
  output logic              SPI_SCK,
  output logic              SPI_CS_N
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg, shreg_sh, hold_reg;
  logic              hold_full, hold_full_nx;
  logic [CW-1:0]     bit_cnt;
  logic              phase;
  logic              accept, frame_end, load_hold, fill;

  always_comb begin
    accept    = write_rq && tx_ready;
    shreg_sh  = shreg << 1;
    frame_end = (state == SHIFT) && phase && (bit_cnt == LAST_BIT);
    // Held byte moves into the shifter either from IDLE or seamlessly at frame end.
    load_hold = hold_full && ((state == IDLE) || frame_end);
    fill      = accept && (state != IDLE);
    hold_full_nx = hold_full;
    if (load_hold) hold_full_nx = 1'b0;
    if (fill)      hold_full_nx = 1'b1;
  end

  always_ff @(posedge spi_clk) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
      phase     <= 1'b0;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      SPI_MOSI  <= 1'b0;
      SPI_SCK   <= 1'b0;
      SPI_CS_N  <= 1'b1;
    end else begin
      hold_full <= hold_full_nx;
      tx_ready  <= !hold_full_nx;
      tx_done   <= 1'b0;
      if (fill) hold_reg <= tx_data;

      case (state)
        IDLE: begin
          if (hold_full || accept) begin
            state    <= SHIFT;
            shreg    <= hold_full ? hold_reg : tx_data;
            SPI_MOSI <= hold_full ? hold_reg[DATA_W-1] : tx_data[DATA_W-1];
            SPI_CS_N <= 1'b0;
            SPI_SCK  <= 1'b0;
            tx_busy  <= 1'b1;
            bit_cnt  <= '0;
            phase    <= 1'b0;
          end
        end
        SHIFT: begin
          if (!phase) begin
            phase   <= 1'b1;
            SPI_SCK <= 1'b1;
          end else begin
            phase   <= 1'b0;
            SPI_SCK <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              if (hold_full) begin
                shreg    <= hold_reg;
                SPI_MOSI <= hold_reg[DATA_W-1];
              end else begin
                state    <= HOLD;
                SPI_MOSI <= 1'b0;
              end
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              shreg    <= shreg_sh;
              SPI_MOSI <= shreg_sh[DATA_W-1];
            end
          end
        end
        HOLD: begin
          state    <= IDLE;
          SPI_CS_N <= 1'b1;
          SPI_SCK  <= 1'b0;
          SPI_MOSI <= 1'b0;
          tx_busy  <= 1'b0;
          tx_done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_module.sv
// Directed bench for spi_tx_module: a monitor reassembles bytes from MOSI at SCK
// rising edges and checks them against a queue of expected bytes.
module tb_spi_tx_module;

  logic       spi_clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = '0;
  logic       write_rq = 1'b0;
  logic       tx_ready, tx_busy, tx_done, SPI_MOSI, SPI_SCK, SPI_CS_N;

  spi_tx_module #(.DATA_W(8)) dut (
    .spi_clk(spi_clk), .reset(reset), .tx_data(tx_data), .write_rq(write_rq),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done),
    .SPI_MOSI(SPI_MOSI), .SPI_SCK(SPI_SCK), .SPI_CS_N(SPI_CS_N)
  );

  always #5 spi_clk = ~spi_clk;

  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];

  bit   mon_en = 1'b0;
  logic prev_sck = 1'b0, prev_cs = 1'b1;
  logic [7:0] sh = '0;
  int bitc = 0, low_run = 0, high_run = 0, last_low_run = 0, last_high_run = 0;
  int done_cnt = 0, sck_rises = 0;

  // Monitor: frame bytes off the wire and score them in order.
  always @(negedge spi_clk) begin
    if (mon_en) begin
      if (tx_done) done_cnt++;
      if (SPI_CS_N) begin
        if (!prev_cs) last_low_run = low_run;
        low_run = 0;
        high_run++;
        bitc = 0;
        checks++;
        if (SPI_SCK !== 1'b0 || SPI_MOSI !== 1'b0) begin
          errors++;
          $display("FAIL idle_lines: sck=%b mosi=%b required 0 0", SPI_SCK, SPI_MOSI);
        end
      end else begin
        if (prev_cs) last_high_run = high_run;
        high_run = 0;
        low_run++;
        if (SPI_SCK && !prev_sck) begin
          sh = {sh[6:0], SPI_MOSI};
          bitc++;
          sck_rises++;
          if (bitc == 8) begin
            bitc = 0;
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL mosi_byte: got %02h with none expected", sh);
            end else begin
              logic [7:0] e;
              e = exp_q.pop_front();
              if (sh !== e) begin
                errors++;
                $display("FAIL mosi_byte: got %02h required %02h", sh, e);
              end
            end
          end
        end
      end
      prev_sck = SPI_SCK;
      prev_cs  = SPI_CS_N;
    end
  end

  task automatic tick();
    @(negedge spi_clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Caller sits just after a negedge; the write is sampled on the next posedge.
  task automatic do_write(input logic [7:0] d);
    tx_data  = d;
    write_rq = 1'b1;
    tick();
    write_rq = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int n;
    n = 0;
    while (done_cnt < target && n < 300) begin
      tick();
      n++;
    end
    chk(name, done_cnt, target);
  endtask

  int d0, r0;

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    mon_en = 1'b1;
    // Reset state
    chk("rst_cs_n", SPI_CS_N, 1);
    chk("rst_sck", SPI_SCK, 0);
    chk("rst_mosi", SPI_MOSI, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    tick();

    // Single frame 0xA5
    exp_q.push_back(8'hA5);
    r0 = sck_rises;
    do_write(8'hA5);
    chk("first_cs_n", SPI_CS_N, 0);
    chk("first_sck", SPI_SCK, 0);
    chk("first_mosi", SPI_MOSI, 1);
    chk("first_ready", tx_ready, 1);
    chk("first_busy", tx_busy, 1);
    wait_done(1, "single_done");
    chk("single_cs_low", last_low_run, 17);
    chk("single_rises", sck_rises - r0, 8);
    repeat (3) tick();

    // Back-to-back 0xA5 then 0x3C
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    do_write(8'hA5);
    repeat (4) tick();
    chk("b2b_ready", tx_ready, 1);
    do_write(8'h3C);
    chk("b2b_full", tx_ready, 0);
    wait_done(2, "b2b_done");
    chk("b2b_cs_low", last_low_run, 33);
    repeat (3) tick();

    // Overflow: 0x33 written while holding register full
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    r0 = sck_rises;
    do_write(8'h11);
    do_write(8'h22);
    chk("ovf_ready", tx_ready, 0);
    do_write(8'h33);
    wait_done(3, "ovf_done");
    chk("ovf_cs_low", last_low_run, 33);
    chk("ovf_rises", sck_rises - r0, 16);
    repeat (5) tick();
    chk("ovf_qempty", exp_q.size(), 0);
    chk("ovf_done_once", done_cnt, 3);

    // Write during HOLD; a write on the transfer edge is ignored
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hC3);
    do_write(8'h5A);
    repeat (16) tick();
    chk("hold_cs_n", SPI_CS_N, 0);
    chk("hold_sck", SPI_SCK, 0);
    chk("hold_mosi", SPI_MOSI, 0);
    chk("hold_busy", tx_busy, 1);
    do_write(8'hC3);
    chk("gap_cs_n", SPI_CS_N, 1);
    chk("gap_done", tx_done, 1);
    chk("gap_ready", tx_ready, 0);
    do_write(8'h77);
    chk("xfer_cs_n", SPI_CS_N, 0);
    chk("xfer_ready", tx_ready, 1);
    chk("xfer_mosi", SPI_MOSI, 1);
    wait_done(5, "hold_done");
    chk("hold_gap_len", last_high_run, 1);
    repeat (5) tick();
    chk("hold_qempty", exp_q.size(), 0);

    // Reset at phase 1 of bit 4 of 0xFF with 0x66 held
    do_write(8'hFF);
    do_write(8'h66);
    repeat (8) tick();
    chk("abort_sck_hi", SPI_SCK, 1);
    d0 = done_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_cs_n", SPI_CS_N, 1);
    chk("abort_sck", SPI_SCK, 0);
    chk("abort_mosi", SPI_MOSI, 0);
    chk("abort_ready", tx_ready, 1);
    chk("abort_done", tx_done, 0);
    repeat (20) tick();
    chk("abort_no_done", done_cnt, d0);
    chk("abort_cs_idle", SPI_CS_N, 1);
    exp_q.push_back(8'h81);
    do_write(8'h81);
    wait_done(d0 + 1, "post_rst_done");
    chk("post_rst_cs_low", last_low_run, 17);
    repeat (5) tick();
    chk("final_qempty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
